// File: rtl/axis_pkg.sv
// Shared constants for the AXI-Stream arbiter and shifter blocks:
// FSM state encoding and one-hot grant encoding.
package axis_pkg;

    localparam int STATE_W = 2;
    localparam int GRANT_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'b00,
        ST_GRANT0 = 2'b01,
        ST_GRANT1 = 2'b10
    } arb_state_t;

    localparam logic [GRANT_W-1:0] GNT_NONE = 2'b00;
    localparam logic [GRANT_W-1:0] GNT_S00  = 2'b01;
    localparam logic [GRANT_W-1:0] GNT_S01  = 2'b10;

    function automatic logic [GRANT_W-1:0] state_to_grant(
        input arb_state_t s
    );
        case (s)
            ST_GRANT0: return GNT_S00;
            ST_GRANT1: return GNT_S01;
            default:   return GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry AXI-Stream register stage (data/strb/last, valid/ready).
// Sustains one beat per cycle when load and unload coincide.
module axis_reg_slice #(
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic [STRB_W-1:0] s_tstrb,
    input  logic              s_tlast,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [STRB_W-1:0] m_tstrb,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready
);

    logic load;

    assign s_tready = !m_tvalid || m_tready;
    assign load     = s_tvalid && s_tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_tdata  <= '0;
            m_tstrb  <= '0;
            m_tlast  <= 1'b0;
            m_tvalid <= 1'b0;
        end else if (load) begin
            m_tdata  <= s_tdata;
            m_tstrb  <= s_tstrb;
            m_tlast  <= s_tlast;
            m_tvalid <= 1'b1;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Two-requester packet-level round-robin arbiter feeding one registered
// AXI-Stream output; a grant is held until the granted packet's tlast.
module axis_rr_arbiter
    import axis_pkg::*;
#(
    parameter int TDATA_WIDTH = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                     axis_aclk,
    input  logic                     axis_aresetn,

    input  logic [TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                     s00_axis_tlast,
    input  logic                     s00_axis_tvalid,
    output logic                     s00_axis_tready,

    input  logic [TDATA_WIDTH-1:0]   s01_axis_tdata,
    input  logic [TDATA_WIDTH/8-1:0] s01_axis_tstrb,
    input  logic                     s01_axis_tlast,
    input  logic                     s01_axis_tvalid,
    output logic                     s01_axis_tready,

    output logic [TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                     m00_axis_tlast,
    output logic                     m00_axis_tvalid,
    input  logic                     m00_axis_tready,

    output logic [STATE_W-1:0]       state,
    output logic [GRANT_W-1:0]       grant,
    output logic [CNT_WIDTH-1:0]     pkt_cnt0,
    output logic [CNT_WIDTH-1:0]     pkt_cnt1
);

    localparam int STRB_W = TDATA_WIDTH / 8;

    arb_state_t             state_q;
    logic                   last_grant;
    logic                   sel0;
    logic                   sel1;
    logic [TDATA_WIDTH-1:0] mux_tdata;
    logic [STRB_W-1:0]      mux_tstrb;
    logic                   mux_tlast;
    logic                   mux_tvalid;
    logic                   slice_ready;
    logic                   accept;

    assign sel0 = (state_q == ST_GRANT0);
    assign sel1 = (state_q == ST_GRANT1);

    always_comb begin
        mux_tdata  = '0;
        mux_tstrb  = '0;
        mux_tlast  = 1'b0;
        mux_tvalid = 1'b0;
        unique case (1'b1)
            sel0: begin
                mux_tdata  = s00_axis_tdata;
                mux_tstrb  = s00_axis_tstrb;
                mux_tlast  = s00_axis_tlast;
                mux_tvalid = s00_axis_tvalid;
            end
            sel1: begin
                mux_tdata  = s01_axis_tdata;
                mux_tstrb  = s01_axis_tstrb;
                mux_tlast  = s01_axis_tlast;
                mux_tvalid = s01_axis_tvalid;
            end
            default: ;
        endcase
    end

    assign s00_axis_tready = sel0 && slice_ready;
    assign s01_axis_tready = sel1 && slice_ready;
    assign accept          = mux_tvalid && slice_ready;

    // last_grant names the requester that lost the next tie
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q    <= ST_IDLE;
            last_grant <= 1'b1;
            pkt_cnt0   <= '0;
            pkt_cnt1   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s00_axis_tvalid &&
                        (!s01_axis_tvalid || last_grant)) begin
                        state_q    <= ST_GRANT0;
                        last_grant <= 1'b0;
                    end else if (s01_axis_tvalid) begin
                        state_q    <= ST_GRANT1;
                        last_grant <= 1'b1;
                    end
                end
                ST_GRANT0: begin
                    if (accept && mux_tlast) begin
                        state_q  <= ST_IDLE;
                        pkt_cnt0 <= pkt_cnt0 + CNT_WIDTH'(1);
                    end
                end
                ST_GRANT1: begin
                    if (accept && mux_tlast) begin
                        state_q  <= ST_IDLE;
                        pkt_cnt1 <= pkt_cnt1 + CNT_WIDTH'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign state = state_q;
    assign grant = state_to_grant(state_q);

    axis_reg_slice #(
        .DATA_W (TDATA_WIDTH),
        .STRB_W (STRB_W)
    ) u_out_slice (
        .aclk     (axis_aclk),
        .aresetn  (axis_aresetn),
        .s_tdata  (mux_tdata),
        .s_tstrb  (mux_tstrb),
        .s_tlast  (mux_tlast),
        .s_tvalid (mux_tvalid),
        .s_tready (slice_ready),
        .m_tdata  (m00_axis_tdata),
        .m_tstrb  (m00_axis_tstrb),
        .m_tlast  (m00_axis_tlast),
        .m_tvalid (m00_axis_tvalid),
        .m_tready (m00_axis_tready)
    );

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: queue-fed source drivers and a
// scoreboard of expected output beats checked at each m00 handshake.
module tb_axis_rr_arbiter;

    localparam int TW = 32;
    localparam int SW = TW / 8;
    localparam int CW = 4;

    typedef struct {
        logic [TW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
        int            gap;
    } beat_t;

    typedef struct {
        logic [TW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [TW-1:0] s00_tdata, s01_tdata, m_tdata;
    logic [SW-1:0] s00_tstrb, s01_tstrb, m_tstrb;
    logic          s00_tlast, s01_tlast, m_tlast;
    logic          s00_tvalid, s01_tvalid, m_tvalid;
    logic          s00_tready, s01_tready, m_tready;
    logic [1:0]    state, grant;
    logic [CW-1:0] pkt_cnt0, pkt_cnt1;

    beat_t q0[$];
    beat_t q1[$];
    exp_t  expq[$];
    logic [1:0] glog[$];
    bit    glog_en;
    int    beats_seen;
    int    tests;
    int    failed;

    axis_rr_arbiter #(
        .TDATA_WIDTH (TW),
        .CNT_WIDTH   (CW)
    ) dut (
        .axis_aclk       (clk),
        .axis_aresetn    (rst_n),
        .s00_axis_tdata  (s00_tdata),
        .s00_axis_tstrb  (s00_tstrb),
        .s00_axis_tlast  (s00_tlast),
        .s00_axis_tvalid (s00_tvalid),
        .s00_axis_tready (s00_tready),
        .s01_axis_tdata  (s01_tdata),
        .s01_axis_tstrb  (s01_tstrb),
        .s01_axis_tlast  (s01_tlast),
        .s01_axis_tvalid (s01_tvalid),
        .s01_axis_tready (s01_tready),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tstrb  (m_tstrb),
        .m00_axis_tlast  (m_tlast),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tready (m_tready),
        .state           (state),
        .grant           (grant),
        .pkt_cnt0        (pkt_cnt0),
        .pkt_cnt1        (pkt_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input int src, input logic [TW-1:0] base,
                            input int n, input int gap_idx,
                            input int gap_len);
        beat_t b;
        exp_t  e;
        for (int i = 0; i < n; i++) begin
            b.data = base + TW'(i) * 32'h10;
            b.strb = (i == n - 1) ? 4'h3 : 4'hF;
            b.last = (i == n - 1);
            b.gap  = (i == gap_idx) ? gap_len : 0;
            e.data = b.data;
            e.strb = b.strb;
            e.last = b.last;
            if (src == 0) q0.push_back(b);
            else          q1.push_back(b);
            expq.push_back(e);
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((expq.size() != 0 || q0.size() != 0 || q1.size() != 0)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain"}, 64'(expq.size() + q0.size() + q1.size()), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_beats(input string tag, input int target);
        int n = 0;
        while (beats_seen < target && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_wait"}, 64'(beats_seen >= target), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        expq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // source 0 driver
    initial begin
        bit acc;
        bit gl;
        int gleft;
        s00_tvalid = 1'b0; s00_tdata = '0; s00_tstrb = '0; s00_tlast = 1'b0;
        gl = 1'b0; gleft = 0;
        forever begin
            @(negedge clk);
            acc = s00_tvalid && s00_tready;
            @(posedge clk);
            #1;
            if (acc && q0.size() > 0) begin
                void'(q0.pop_front());
                gl = 1'b0;
            end
            if (q0.size() > 0) begin
                if (!gl) begin gleft = q0[0].gap; gl = 1'b1; end
                if (gleft > 0) begin
                    gleft--;
                    s00_tvalid = 1'b0;
                end else begin
                    s00_tvalid = 1'b1;
                    s00_tdata  = q0[0].data;
                    s00_tstrb  = q0[0].strb;
                    s00_tlast  = q0[0].last;
                end
            end else begin
                s00_tvalid = 1'b0;
                gl = 1'b0;
            end
        end
    end

    // source 1 driver
    initial begin
        bit acc;
        bit gl;
        int gleft;
        s01_tvalid = 1'b0; s01_tdata = '0; s01_tstrb = '0; s01_tlast = 1'b0;
        gl = 1'b0; gleft = 0;
        forever begin
            @(negedge clk);
            acc = s01_tvalid && s01_tready;
            @(posedge clk);
            #1;
            if (acc && q1.size() > 0) begin
                void'(q1.pop_front());
                gl = 1'b0;
            end
            if (q1.size() > 0) begin
                if (!gl) begin gleft = q1[0].gap; gl = 1'b1; end
                if (gleft > 0) begin
                    gleft--;
                    s01_tvalid = 1'b0;
                end else begin
                    s01_tvalid = 1'b1;
                    s01_tdata  = q1[0].data;
                    s01_tstrb  = q1[0].strb;
                    s01_tlast  = q1[0].last;
                end
            end else begin
                s01_tvalid = 1'b0;
                gl = 1'b0;
            end
        end
    end

    // output monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (glog_en) glog.push_back(grant);
            if (rst_n && m_tvalid && m_tready) begin
                beats_seen++;
                chk("sb_nonempty", 64'(expq.size() > 0), 1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("beat_data", m_tdata, e.data);
                    chk("beat_strb", m_tstrb, e.strb);
                    chk("beat_last", m_tlast, e.last);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] c[$];
        int         r[$];
        logic [1:0] tie_exp [5];
        int         b0;

        tests = 0; failed = 0; beats_seen = 0; glog_en = 1'b0;
        tie_exp = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        rst_n = 1'b0;
        m_tready = 1'b1;
        #1;
        chk("rst_state", state, 2'b00);
        chk("rst_grant", grant, 2'b00);
        chk("rst_mvalid", m_tvalid, 0);
        chk("rst_cnt0", pkt_cnt0, 0);
        chk("rst_cnt1", pkt_cnt1, 0);
        chk("rst_rdy0", s00_tready, 0);
        chk("rst_rdy1", s01_tready, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // single requester, 3 beats, latency and back-to-back output
        push_pkt(0, 32'h10, 3, -1, 0);
        @(negedge clk);
        chk("s1_idle", state, 2'b00);
        @(negedge clk);
        chk("s1_grant", state, 2'b01);
        chk("s1_nvalid", m_tvalid, 0);
        @(negedge clk);
        chk("s1_v0", m_tvalid, 1);
        chk("s1_d0", m_tdata, 32'h10);
        @(negedge clk);
        chk("s1_d1", m_tdata, 32'h20);
        @(negedge clk);
        chk("s1_d2", m_tdata, 32'h30);
        chk("s1_last", m_tlast, 1);
        chk("s1_back_idle", state, 2'b00);
        wait_drain("s1", 100);
        chk("s1_cnt0", pkt_cnt0, 1);
        chk("s1_state", state, 2'b00);

        // tie after reset: s00 first, one bubble, then s01
        do_reset();
        glog.delete();
        glog_en = 1'b1;
        push_pkt(0, 32'h100, 2, -1, 0);
        push_pkt(1, 32'h200, 2, -1, 0);
        wait_drain("tie", 100);
        glog_en = 1'b0;
        c.delete();
        r.delete();
        foreach (glog[i]) begin
            if (c.size() == 0 || c[c.size()-1] != glog[i]) begin
                c.push_back(glog[i]);
                r.push_back(1);
            end else begin
                r[r.size()-1] = r[r.size()-1] + 1;
            end
        end
        chk("tie_len", 64'(c.size()), 5);
        for (int i = 0; i < 5 && i < c.size(); i++)
            chk($sformatf("tie_grant%0d", i), c[i], tie_exp[i]);
        if (r.size() > 2) chk("tie_bubble", 64'(r[2]), 1);
        chk("tie_cnt0", pkt_cnt0, 1);
        chk("tie_cnt1", pkt_cnt1, 1);

        // fairness: alternating single-beat packets
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_pkt(0, 32'h1000 + TW'(i), 1, -1, 0);
            push_pkt(1, 32'h2000 + TW'(i), 1, -1, 0);
        end
        wait_drain("fair", 200);
        chk("fair_cnt0", pkt_cnt0, 4);
        chk("fair_cnt1", pkt_cnt1, 4);

        // backpressure for 5 cycles mid-packet
        do_reset();
        b0 = beats_seen;
        push_pkt(0, 32'h300, 4, -1, 0);
        wait_beats("bp", b0 + 1);
        @(posedge clk);
        #1;
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_valid%0d", i), m_tvalid, 1);
            chk($sformatf("bp_data%0d", i), m_tdata, 32'h310);
            chk($sformatf("bp_rdy%0d", i), s00_tready, 0);
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        wait_drain("bp", 100);
        chk("bp_cnt0", pkt_cnt0, 1);

        // requester gap mid-packet keeps grant despite other tvalid
        do_reset();
        b0 = beats_seen;
        push_pkt(0, 32'h400, 3, 1, 4);
        push_pkt(1, 32'h500, 1, -1, 0);
        wait_beats("gap", b0 + 1);
        @(negedge clk);
        chk("gap_grant", grant, 2'b01);
        chk("gap_rdy1", s01_tready, 0);
        wait_drain("gap", 100);
        chk("gap_cnt0", pkt_cnt0, 1);
        chk("gap_cnt1", pkt_cnt1, 1);

        // asynchronous reset mid-packet, then fresh arbitration
        do_reset();
        b0 = beats_seen;
        push_pkt(0, 32'h600, 4, -1, 0);
        wait_beats("mrst", b0 + 2);
        #2;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        expq.delete();
        #1;
        chk("mrst_state", state, 2'b00);
        chk("mrst_grant", grant, 2'b00);
        chk("mrst_valid", m_tvalid, 0);
        chk("mrst_last", m_tlast, 0);
        chk("mrst_data", m_tdata, 0);
        chk("mrst_strb", m_tstrb, 0);
        chk("mrst_cnt0", pkt_cnt0, 0);
        chk("mrst_rdy0", s00_tready, 0);
        chk("mrst_rdy1", s01_tready, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_pkt(0, 32'h800, 2, -1, 0);
        push_pkt(1, 32'h900, 1, -1, 0);
        wait_drain("mrst", 100);
        chk("mrst_pcnt0", pkt_cnt0, 1);
        chk("mrst_pcnt1", pkt_cnt1, 1);

        // 4-bit counter wrap: 17 packets on s01
        do_reset();
        for (int i = 0; i < 17; i++)
            push_pkt(1, 32'hA00 + TW'(i), 1, -1, 0);
        wait_drain("wrap", 300);
        chk("wrap_cnt1", pkt_cnt1, 1);
        chk("wrap_cnt0", pkt_cnt0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
